// File: rtl/oled_pkg.sv
// oled_pkg: shared OLED SPI byte type, dc tag constants and sink state encoding
package oled_pkg;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } oled_spi_byte_t;

    localparam logic OLED_CMD  = 1'b0;
    localparam logic OLED_DATA = 1'b1;

    typedef enum logic {
        IDLE,
        SHIFT
    } sink_state_e;

endpackage

// File: rtl/spi_oled_sink_if.sv
// spi_oled_sink_if: SPI input lines plus the tagged byte output stream
interface spi_oled_sink_if #(
    parameter int PACKET_WIDTH = 8
);
    logic                    cs;
    logic                    sclk;
    logic                    sdin;
    logic                    dc;
    logic [PACKET_WIDTH-1:0] out_data;
    logic                    out_dc;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overflow;
    logic                    frame_error;

    modport master (
        output cs, sclk, sdin, dc, out_ready,
        input  out_data, out_dc, out_valid, overflow, frame_error
    );

    modport slave (
        input  cs, sclk, sdin, dc, out_ready,
        output out_data, out_dc, out_valid, overflow, frame_error
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers, push accepted when full if popping
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
    logic             wr_en, rd_en;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign wr_d    = wr_q + (AW+1)'(wr_en);
    assign rd_d    = rd_q + (AW+1)'(rd_en);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Advance pointers and store the pushed word; storage clears so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/spi_oled_sink.sv
// spi_oled_sink: SPI mode-0 target that deserializes dc-tagged OLED bytes into a FIFO stream
module spi_oled_sink
    import oled_pkg::*;
#(
    parameter int PACKET_WIDTH = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input logic            clk,
    input logic            reset_n,
    spi_oled_sink_if.slave bus
);
    localparam int CW = $clog2(PACKET_WIDTH);

    logic [SYNC_STAGES-1:0]  cs_sync_q, sclk_sync_q, sdin_sync_q, dc_sync_q;
    logic                    sclk_q;
    logic                    cs_s, sclk_s, sdin_s, dc_s, rise;
    sink_state_e             state_q;
    logic [CW-1:0]           cnt_q;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic                    frame_error_q, overflow_q;
    logic                    push, pop, full, empty, last_bit;
    oled_spi_byte_t          push_word, head_word;

    // Bring the asynchronous SPI lines into clk, resetting to bus-idle levels
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            sdin_sync_q <= '0;
            dc_sync_q   <= '0;
            sclk_q      <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], bus.sdin};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], bus.dc};
            sclk_q      <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
    assign dc_s      = dc_sync_q[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_q;
    assign last_bit  = cnt_q == CW'(PACKET_WIDTH - 1);
    assign shift_d   = {shift_q[PACKET_WIDTH-2:0], sdin_s};
    assign push      = (state_q == SHIFT) & ~cs_s & rise & last_bit;
    assign pop       = ~empty & bus.out_ready;
    assign push_word = '{dc: dc_s, data: shift_d};

    // Frame FSM: shift on sclk rises while selected; cs release wins over a coincident rise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            if (push & full & ~pop) overflow_q <= 1'b1;
            case (state_q)
                IDLE: if (!cs_s) state_q <= SHIFT;
                SHIFT: begin
                    if (cs_s) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        frame_error_q <= cnt_q != '0;
                    end else if (rise) begin
                        shift_q <= shift_d;
                        cnt_q   <= last_bit ? '0 : cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH($bits(oled_spi_byte_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push_i (push),
        .data_i (push_word),
        .pop_i  (pop),
        .data_o (head_word),
        .full_o (full),
        .empty_o(empty)
    );

    assign bus.out_data    = head_word.data;
    assign bus.out_dc      = head_word.dc;
    assign bus.out_valid   = ~empty;
    assign bus.overflow    = overflow_q;
    assign bus.frame_error = frame_error_q;
endmodule

// File: tb/tb_spi_oled_sink.sv
// tb_spi_oled_sink: directed and random SPI frames checked against a queue model of the byte stream
module tb_spi_oled_sink;
    import oled_pkg::*;

    localparam int PW    = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    int         n_assert = 0;
    int         n_fail = 0;
    int         fe_cnt = 0;
    int         fe0;
    int         nb;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    logic       ovf_m;
    logic [7:0] v;
    logic       d;

    spi_oled_sink_if #(.PACKET_WIDTH(PW)) bus ();

    spi_oled_sink #(
        .PACKET_WIDTH(PW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Record every accepted handshake and every cycle frame_error is high
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) got.push_back({bus.out_dc, bus.out_data});
        if (bus.frame_error) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One bit at sclk = clk/8; optionally pops on the push edge or checks out_valid latency
    task automatic send_bit(input logic b, input logic dd, input bit pop, input bit meas);
        bus.sdin = b;
        bus.dc   = dd;
        repeat (4) @(negedge clk);
        bus.sclk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (meas && k <= SS + 1) chk("latency_valid", 32'(bus.out_valid), 32'(k == SS + 1));
            if (pop && k == SS) bus.out_ready = 1'b1;
            if (pop && k == SS + 1) bus.out_ready = 1'b0;
        end
        bus.sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] val, input logic dd, input bit pop, input bit meas);
        for (int i = 7; i >= 0; i--) send_bit(val[i], dd, pop && i == 0, meas && i == 0);
    endtask

    task automatic start_frame();
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        bus.cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && bus.out_valid; i++) @(negedge clk);
        bus.out_ready = 1'b0;
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.cs  = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        got.delete();
        ovf_m = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.cs        = 1'b0;
        bus.sclk      = 1'b0;
        bus.sdin      = 1'b0;
        bus.dc        = 1'b0;
        bus.out_ready = 1'b0;
        ovf_m         = 1'b0;

        // Reset held while the host is mid-frame and clocking
        for (int i = 0; i < 8; i++) begin
            repeat (2) @(negedge clk);
            bus.sclk = ~bus.sclk;
            bus.sdin = 1'($urandom);
        end
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_frame_error", 32'(bus.frame_error), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_dc", 32'(bus.out_dc), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        v = 8'($urandom);
        d = 1'($urandom);
        send_byte(v, d, 0, 0);
        exp_q.push_back({d, v});
        chk("post_reset_valid", 32'(bus.out_valid), 32'd1);
        end_frame();
        drain();
        cmp_stream("post_reset");
        chk("post_reset_fe", 32'(fe_cnt), 32'd0);

        // Single command byte with latency check
        start_frame();
        send_byte(8'hAF, OLED_CMD, 0, 1);
        chk("single_data", 32'(bus.out_data), 32'hAF);
        chk("single_dc", 32'(bus.out_dc), 32'(OLED_CMD));
        exp_q.push_back({OLED_CMD, 8'hAF});
        end_frame();
        drain();
        cmp_stream("single");

        // Back-to-back bytes in one frame, consumer always ready
        bus.out_ready = 1'b1;
        start_frame();
        send_byte(8'h15, OLED_CMD, 0, 0);
        send_byte(8'h00, OLED_DATA, 0, 0);
        send_byte(8'h5F, OLED_DATA, 0, 0);
        exp_q.push_back({OLED_CMD, 8'h15});
        exp_q.push_back({OLED_DATA, 8'h00});
        exp_q.push_back({OLED_DATA, 8'h5F});
        end_frame();
        bus.out_ready = 1'b0;
        cmp_stream("three_bytes");

        // Random frames streaming through
        for (int f = 0; f < 4; f++) begin
            bus.out_ready = 1'b1;
            nb = int'($urandom_range(1, 4));
            start_frame();
            for (int b = 0; b < nb; b++) begin
                v = 8'($urandom);
                d = 1'($urandom);
                send_byte(v, d, 0, 0);
                exp_q.push_back({d, v});
            end
            end_frame();
            bus.out_ready = 1'b0;
            cmp_stream("random_frame");
        end

        // Six bytes into a stalled consumer: first DEPTH kept, rest dropped
        start_frame();
        for (int b = 0; b < 6; b++) begin
            v = 8'($urandom);
            d = 1'($urandom);
            send_byte(v, d, 0, 0);
            if (exp_q.size() < DEPTH) exp_q.push_back({d, v});
            else ovf_m = 1'b1;
        end
        end_frame();
        chk("overflow_set", 32'(bus.overflow), 32'(ovf_m));
        chk("overflow_valid", 32'(bus.out_valid), 32'd1);
        drain();
        cmp_stream("overflow_fifo");

        // Abort after five bits, then a clean byte
        fe0 = fe_cnt;
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0, 0, 0);
        bus.cs = 1'b1;
        for (int k = 1; k <= SS + 2; k++) begin
            @(negedge clk);
            chk("frame_error_pulse", 32'(bus.frame_error), 32'(k == SS + 1));
        end
        repeat (6) @(negedge clk);
        start_frame();
        send_byte(8'h3C, OLED_DATA, 0, 0);
        exp_q.push_back({OLED_DATA, 8'h3C});
        end_frame();
        drain();
        cmp_stream("after_abort");
        chk("abort_fe_count", 32'(fe_cnt - fe0), 32'd1);
        chk("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Push into a full FIFO on the same edge as a pop
        do_reset();
        chk("reset_clears_overflow", 32'(bus.overflow), 32'd0);
        start_frame();
        for (int b = 0; b < 5; b++) begin
            v = 8'($urandom);
            d = 1'($urandom);
            send_byte(v, d, b == 4, 0);
            if (b == 4 || exp_q.size() < DEPTH) exp_q.push_back({d, v});
            else ovf_m = 1'b1;
        end
        chk("full_pop_overflow", 32'(bus.overflow), 32'(ovf_m));
        chk("full_pop_valid", 32'(bus.out_valid), 32'd1);
        end_frame();
        drain();
        cmp_stream("full_pop");

        // sclk activity with cs high must be ignored
        fe0 = fe_cnt;
        for (int i = 0; i < 10; i++) begin
            repeat (2) @(negedge clk);
            bus.sclk = 1'b1;
            bus.sdin = 1'($urandom);
            repeat (2) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("idle_sclk_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_sclk_got", 32'(got.size()), 32'd0);
        chk("idle_sclk_fe", 32'(fe_cnt - fe0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
